// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared types and constants for the ALU issue sequencer
package alu_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  // Instruction field positions
  localparam int RX_HI      = 15;
  localparam int RX_LO      = 13;
  localparam int RY_HI      = 12;
  localparam int RY_LO      = 10;
  localparam int SEL_HI     = 9;
  localparam int SEL_LO     = 6;
  localparam int CIN_EN_BIT = 5;

  // ALU select encodings understood by the downstream ALU
  localparam logic [3:0] SEL_ONE = 4'd0;
  localparam logic [3:0] SEL_ADD = 4'd2;
  localparam logic [3:0] SEL_SUB = 4'd3;
  localparam logic [3:0] SEL_DBL = 4'd6;
  localparam logic [3:0] SEL_INC = 4'd7;

  // Any select with this bit set is outside the ALU's opcode space
  localparam int SEL_ILLEGAL_BIT = 3;

  function automatic logic sel_is_illegal(input logic [3:0] sel);
    return sel[SEL_ILLEGAL_BIT];
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file with one write port and two combinational read ports
module alu_regfile #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Single write port; whole array clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - execute-stage sequencer feeding a combinational ALU
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              ld_en,
  input  logic [2:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_sel,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_cout,
  input  logic              alu_cmp,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic              carry_flag,
  output logic              cmp_flag,
  output logic              busy
);

  state_t            state;
  logic [2:0]        rx_q;
  logic [2:0]        ry_q;
  logic [3:0]        sel_q;
  logic              cin_en_q;
  logic [DATA_W-1:0] res_q;
  logic              cout_q;
  logic              cmp_q;

  logic              accept;
  logic              rf_we;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              unused_instr_bits;

  assign unused_instr_bits = ^instr[4:0];

  // A coincident load takes the IDLE cycle, so the instruction waits
  assign instr_ready = (state == IDLE) && !ld_en;
  assign accept      = instr_valid && instr_ready;
  assign busy        = (state != IDLE);

  // Loads only land in IDLE; write-back only in WB, so the two never collide
  assign rf_we    = ((state == IDLE) && ld_en) ||
                    ((state == WB) && !sel_is_illegal(sel_q));
  assign rf_waddr = (state == IDLE) ? ld_addr : rx_q;
  assign rf_wdata = (state == IDLE) ? ld_data : res_q;

  alu_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (3)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (rf_wdata),
    .raddr_a(rx_q),
    .rdata_a(rd_a),
    .raddr_b(ry_q),
    .rdata_b(rd_b)
  );

  // Issue sequencer: latch, drive ALU, capture, write back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_q       <= '0;
      ry_q       <= '0;
      sel_q      <= '0;
      cin_en_q   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      alu_cin    <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      cmp_q      <= 1'b0;
      result     <= '0;
      carry_flag <= 1'b0;
      cmp_flag   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            rx_q     <= instr[RX_HI:RX_LO];
            ry_q     <= instr[RY_HI:RY_LO];
            sel_q    <= instr[SEL_HI:SEL_LO];
            cin_en_q <= instr[CIN_EN_BIT];
            state    <= FETCH;
          end
        end
        FETCH: begin
          alu_a   <= rd_a;
          alu_b   <= rd_b;
          alu_sel <= sel_q;
          alu_cin <= cin_en_q & carry_flag;
          state   <= EXEC;
        end
        EXEC: begin
          res_q  <= alu_res;
          cout_q <= alu_cout;
          cmp_q  <= alu_cmp;
          done   <= 1'b1;
          err    <= sel_is_illegal(sel_q);
          state  <= WB;
        end
        WB: begin
          if (!sel_is_illegal(sel_q)) begin
            result     <= res_q;
            carry_flag <= cout_q;
            cmp_flag   <= cmp_q;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Execute-stage sequencer that sits directly upstream of the team's 16-bit combinational ALU.
- Accepts one instruction per valid/ready handshake.
- Reads two operands from an internal 8-entry register file and drives the ALU operand, select and carry-in lines.
- Captures the ALU result, carry and compare outputs.
- Writes the result back and keeps sticky carry/compare flags for the following instruction.

Parameters:
- DATA_W, 16, datapath and register width; must match the ALU width.
- NUM_REGS, 8, register-file depth; fixed by the 3-bit register fields in the instruction.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  block can accept an instruction (IDLE only).
- instr  input  16  instruction fields:
  - [15:13] rx: destination register and A-operand register.
  - [12:10] ry: B-operand register.
  - [9:6] sel: ALU select.
  - [5] cin_en: use the stored carry flag as ALU carry-in.
  - [4:0] reserved, ignored.
- ld_en  input  1  external register-file load strobe.
- ld_addr  input  3  load target register.
- ld_data  input  DATA_W  load value.
- alu_a  output  DATA_W  ALU operand A (registered).
- alu_b  output  DATA_W  ALU operand B (registered).
- alu_sel  output  4  ALU select (registered).
- alu_cin  output  1  ALU carry-in (registered).
- alu_res  input  DATA_W  ALU result.
- alu_cout  input  1  ALU carry out.
- alu_cmp  input  1  ALU equality output.
- done  output  1  one-cycle pulse marking instruction completion.
- err  output  1  one-cycle pulse, concurrent with done, for an illegal sel.
- result  output  DATA_W  last written-back value; held until the next done.
- carry_flag  output  1  sticky carry.
- cmp_flag  output  1  sticky compare.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; all register-file entries, alu_a/alu_b/alu_sel/alu_cin, result, carry_flag, cmp_flag, done and err go to 0. Reset asserted mid-instruction aborts it: no write-back, no done.
- FSM states: IDLE -> FETCH -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready=1. On instr_valid at the edge, latch instr and go to FETCH.
  - FETCH:
    - alu_a <= rf[rx] and alu_b <= rf[ry] (combinational register-file read).
    - alu_sel <= sel.
    - alu_cin <= cin_en ? carry_flag : 0.
    - Go to EXEC.
  - EXEC: ALU inputs stable for a full cycle. At the edge, capture alu_res/alu_cout/alu_cmp into internal holding regs; go to WB.
  - WB, legal sel (sel[3]=0):
    - done=1.
    - rf[rx] <= captured result; result <= captured result.
    - carry_flag <= captured carry; cmp_flag <= captured compare.
  - WB, illegal sel (sel[3]=1): done=1 and err=1; no register-file write; result and flags unchanged. Always return to IDLE.
- Latency: accept at edge k, so done is high during the cycle after edge k+2, and the write-back is visible at edge k+3. Next accept happens no earlier than the IDLE cycle after WB; throughput is 1 instruction per 4 cycles.
- alu_* outputs hold their last values outside FETCH updates. No combinational path from instr or alu_* inputs to any output.
- rx == ry: both operands come from the same register.
- rx is overwritten in WB. A following instruction reading rx sees the new value, since FETCH is always at least 2 cycles after WB.
- ld_en:
  - Writes rf[ld_addr] only when state==IDLE and no instruction is accepted that same edge.
  - If ld_en and an accepted instr_valid coincide, the load wins and instr_ready is driven 0 that cycle.
  - ld_en while busy is ignored (dropped).
- Flags persist across instructions until the next legal WB. cin_en uses the flag value from before the current instruction.
- Arithmetic is performed solely in the ALU. Values wrap modulo 2^DATA_W as the ALU produces them.

Decomposition:
- Shared package:
  - State enum (IDLE, FETCH, EXEC, WB).
  - Instruction field position constants (RX_HI/LO, RY_HI/LO, SEL_HI/LO, CIN_EN_BIT).
  - ALU select encodings: SEL_ONE=0, SEL_ADD=2, SEL_SUB=3, SEL_DBL=6, SEL_INC=7.
  - SEL_ILLEGAL_BIT=3.
- One sub-module, alu_regfile: 8xDATA_W registers, one write port, two combinational read ports, async active-low clear.

Test Plan:
- Bench instantiates the team ALU.
- Load R1=0x0005, R2=0x0003; issue rx=1, ry=2, sel=2, cin_en=0. Expect done 3 cycles after accept, R1=result=0x0008, carry_flag=0, cmp_flag=0.
- Load R3=0xFFFF, R4=0x0001; add sel=2 gives R3=0x0000, carry_flag=1. Then R5=R6=0 with sel=2, cin_en=1 gives R5=0x0001, carry_flag=0.
- R2=0x1234 and rx=ry=2, sel=7, cin_en=0: cmp_flag=1, R2=0x1235. Next instruction sel=0 on R7: R7=0x0001, cmp_flag reflects R7==R7=1.
- Illegal sel=9 on rx=1 (R1=0x00AA): done=1 and err=1; R1 stays 0x00AA; result and flags unchanged.
- Accept an instruction, then pulse rst_n low during EXEC: no done, all registers 0, instr_ready=1 on release. ld_en during FETCH is dropped. ld_en together with instr_valid in IDLE: load performed, instruction not accepted.
- Back-to-back instr_valid held high for 3 instructions: exactly 3 done pulses, 4 cycles apart, each writing the correct register.
